// File: rtl/scan_misr.sv
// scan_misr: serial signature analyser for the capture end of a scan BIST path.
//
// Compacts the scan-chain tail stream into a single-input signature register.
// A session starts with `start`. Every `mode`-qualified bit is handled in order:
//   - the first SKIP_BITS bits are discarded,
//   - the next PATTERN_BITS bits are compacted.
// After that the signature is compared with GOLDEN, and `done`/`pass` report the result.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   single-cycle session start (honoured in IDLE/DONE only)
//   mode       in   shift enable; one scan bit valid per clock while high
//   scan_out   in   serial data from the scan chain tail
//   busy       out  high in SKIP, COMPACT and CHECK
//   done       out  high in DONE
//   pass       out  valid while done; 1 = signature matched GOLDEN
//   signature  out  live signature register
//   sig_serial out  (SCAN_MISR_SERIAL_UNLOAD_EN) unloaded signature bit, MSB first
//   sig_valid  out  (SCAN_MISR_SERIAL_UNLOAD_EN) sig_serial qualifier
//
// Optional feature macro: SCAN_MISR_SERIAL_UNLOAD_EN adds the serial unload port pair.

module scan_misr #(
  parameter int unsigned          SIG_BITS     = 8,
  parameter logic [SIG_BITS-1:0]  TAPS         = SIG_BITS'(8'h1D),
  parameter int unsigned          PATTERN_BITS = 255,
  parameter int unsigned          SKIP_BITS    = 1,
  parameter logic [SIG_BITS-1:0]  GOLDEN       = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic                scan_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
`ifdef SCAN_MISR_SERIAL_UNLOAD_EN
  output logic                sig_serial,
  output logic                sig_valid,
`endif
  output logic [SIG_BITS-1:0] signature
);

  // A zero-width counter is not legal, so a 1-bit one stands in when no bits are skipped.
  localparam int unsigned SkipW = (SKIP_BITS > 0) ? $clog2(SKIP_BITS + 1) : 1;
  localparam int unsigned BitW  = $clog2(PATTERN_BITS + 1);

  localparam logic [SkipW-1:0] SkipLast = SkipW'(SKIP_BITS);
  localparam logic [BitW-1:0]  BitLast  = BitW'(PATTERN_BITS);

  typedef enum logic [2:0] {StIdle, StSkip, StCompact, StCheck, StDone} state_e;

  state_e              state_q, state_d;
  logic [SIG_BITS-1:0] sig_q, sig_d;
  logic [SkipW-1:0]    skip_cnt_q, skip_cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                pass_q, pass_d;
  logic                fb;

  assign fb = ^(sig_q & TAPS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sig_q      <= '0;
      skip_cnt_q <= '0;
      bit_cnt_q  <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      skip_cnt_q <= skip_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    skip_cnt_d = skip_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pass_d     = pass_q;

    case (state_q)
      StIdle, StDone: begin
        // A mode bit in the start cycle is deliberately neither counted nor compacted.
        if (start) begin
          sig_d      = '0;
          skip_cnt_d = '0;
          bit_cnt_d  = '0;
          pass_d     = 1'b0;
          state_d    = (SKIP_BITS > 0) ? StSkip : StCompact;
        end
      end

      StSkip: begin
        if (mode) begin
          skip_cnt_d = skip_cnt_q + 1'b1;
          if (skip_cnt_d == SkipLast) begin
            state_d = StCompact;
          end
        end
      end

      StCompact: begin
        if (mode) begin
          sig_d     = {sig_q[SIG_BITS-2:0], scan_out ^ fb};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == BitLast) begin
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        pass_d  = (sig_q == GOLDEN);
        state_d = StDone;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q == StSkip) || (state_q == StCompact) || (state_q == StCheck);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign signature = sig_q;

`ifdef SCAN_MISR_SERIAL_UNLOAD_EN
  localparam int unsigned UnW = $clog2(SIG_BITS + 1);

  // Shadow copy so the live signature port stays untouched while unloading.
  logic [SIG_BITS-1:0] unload_q;
  logic [UnW-1:0]      unload_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      unload_q     <= '0;
      unload_cnt_q <= '0;
    end else if (state_q == StCheck) begin
      unload_q     <= sig_q;
      unload_cnt_q <= UnW'(SIG_BITS);
    end else if ((state_q == StDone) && start) begin
      unload_q     <= '0;
      unload_cnt_q <= '0;
    end else if (unload_cnt_q != '0) begin
      unload_q     <= {unload_q[SIG_BITS-2:0], 1'b0};
      unload_cnt_q <= unload_cnt_q - 1'b1;
    end
  end

  assign sig_valid  = (unload_cnt_q != '0);
  assign sig_serial = sig_valid & unload_q[SIG_BITS-1];
`endif

endmodule

// File: tb/tb_scan_misr.sv
// Bench for scan_misr. Four instances share the reset:
//   u_a/u_b  plain shift (TAPS=0, no skip, 4 bits), GOLDEN 0B / 0C, driven by a vector table
//   u_c      skip of one bit plus mode gaps, hand-written sequence
//   u_d      default parameters: long sessions, restart from DONE, reset mid-session
module tb_scan_misr;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic st1, md1, so1, st2, md2, so2, st3, md3, so3;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic busy_c, done_c, pass_c, busy_d, done_d, pass_d;
  logic [7:0] sig_a, sig_b, sig_c, sig_d;
`ifdef SCAN_MISR_SERIAL_UNLOAD_EN
  logic ser_a, val_a, ser_b, val_b, ser_c, val_c, ser_d, val_d;
`endif

  scan_misr #(.SIG_BITS(8), .TAPS(8'h00), .PATTERN_BITS(4), .SKIP_BITS(0), .GOLDEN(8'h0B)) u_a (
    .clock(clock), .reset(reset), .start(st1), .mode(md1), .scan_out(so1),
    .busy(busy_a), .done(done_a), .pass(pass_a),
`ifdef SCAN_MISR_SERIAL_UNLOAD_EN
    .sig_serial(ser_a), .sig_valid(val_a),
`endif
    .signature(sig_a));

  scan_misr #(.SIG_BITS(8), .TAPS(8'h00), .PATTERN_BITS(4), .SKIP_BITS(0), .GOLDEN(8'h0C)) u_b (
    .clock(clock), .reset(reset), .start(st1), .mode(md1), .scan_out(so1),
    .busy(busy_b), .done(done_b), .pass(pass_b),
`ifdef SCAN_MISR_SERIAL_UNLOAD_EN
    .sig_serial(ser_b), .sig_valid(val_b),
`endif
    .signature(sig_b));

  scan_misr #(.SIG_BITS(8), .TAPS(8'h00), .PATTERN_BITS(4), .SKIP_BITS(1), .GOLDEN(8'h0B)) u_c (
    .clock(clock), .reset(reset), .start(st2), .mode(md2), .scan_out(so2),
    .busy(busy_c), .done(done_c), .pass(pass_c),
`ifdef SCAN_MISR_SERIAL_UNLOAD_EN
    .sig_serial(ser_c), .sig_valid(val_c),
`endif
    .signature(sig_c));

  scan_misr u_d (
    .clock(clock), .reset(reset), .start(st3), .mode(md3), .scan_out(so3),
    .busy(busy_d), .done(done_d), .pass(pass_d),
`ifdef SCAN_MISR_SERIAL_UNLOAD_EN
    .sig_serial(ser_d), .sig_valid(val_d),
`endif
    .signature(sig_d));

  typedef struct {
    logic       start;
    logic       mode;
    logic       so;
    logic       busy;
    logic       done;
    logic       pass_a;
    logic       pass_b;
    logic [7:0] sig;
  } vec_t;

  vec_t vecs [15];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference signature for the default polynomial: one 1 (or 0) then 254 zeros.
  function automatic logic [7:0] ref_sig(input logic first_one);
    logic [7:0] s;
    logic       b;
    s = 8'h00;
    for (int i = 0; i < 255; i++) begin
      b = (i == 0) ? first_one : 1'b0;
      s = {s[6:0], b ^ s[0] ^ s[2] ^ s[3] ^ s[4]};
    end
    return s;
  endfunction

  // Full default session on u_d: start, 1 skipped bit, 255 compacted bits.
  task automatic session_d(input logic first_one);
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    chk1("d start done", done_d, 1'b0);
    chk8("d start sig", sig_d, 8'h00);
    chk1("d start busy", busy_d, 1'b1);
    md3 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      so3 = (i == 1) ? first_one : 1'b0;
      tick();
    end
    md3 = 1'b0;
    so3 = 1'b0;
    chk1("d check-state done", done_d, 1'b0);
    chk1("d check-state busy", busy_d, 1'b1);
    tick();
    chk1("d done", done_d, 1'b1);
    chk1("d busy low", busy_d, 1'b0);
    chk8("d sig", sig_d, ref_sig(first_one));
    chk1("d pass", pass_d, ~first_one);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    //                start  mode   so     busy   done   pass_a pass_b sig
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0B};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0B};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0B};

    {st1, md1, so1, st2, md2, so2, st3, md3, so3} = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk1("reset busy", busy_d, 1'b0);
    chk1("reset done", done_d, 1'b0);
    chk1("reset pass", pass_d, 1'b0);
    chk8("reset sig", sig_d, 8'h00);
    tick();

    // Plain shift, hold in DONE, restart from DONE, start ignored while busy, mode gap.
    for (int i = 0; i < 15; i++) begin
      st1 = vecs[i].start;
      md1 = vecs[i].mode;
      so1 = vecs[i].so;
      tick();
      chk1($sformatf("vec%0d busy", i), busy_a, vecs[i].busy);
      chk1($sformatf("vec%0d done", i), done_a, vecs[i].done);
      chk1($sformatf("vec%0d pass_a", i), pass_a, vecs[i].pass_a);
      chk8($sformatf("vec%0d sig_a", i), sig_a, vecs[i].sig);
      chk1($sformatf("vec%0d done_b", i), done_b, vecs[i].done);
      chk1($sformatf("vec%0d pass_b", i), pass_b, vecs[i].pass_b);
      chk8($sformatf("vec%0d sig_b", i), sig_b, vecs[i].sig);
    end
    {st1, md1, so1} = '0;

    // Skip one bit, then a 3-cycle mode gap mid-stream.
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    chk1("c start busy", busy_c, 1'b1);
    md2 = 1'b1; so2 = 1'b0; tick();
    chk8("c after skip", sig_c, 8'h00);
    so2 = 1'b1; tick();
    chk8("c bit1", sig_c, 8'h01);
    so2 = 1'b0; tick();
    md2 = 1'b0; so2 = 1'b1;
    tick(); tick(); tick();
    chk8("c gap hold", sig_c, 8'h02);
    chk1("c gap busy", busy_c, 1'b1);
    md2 = 1'b1; so2 = 1'b1; tick();
    so2 = 1'b1; tick();
    md2 = 1'b0; so2 = 1'b0;
    chk1("c check-state done", done_c, 1'b0);
    tick();
    chk1("c done", done_c, 1'b1);
    chk1("c pass", pass_c, 1'b1);
    chk8("c sig", sig_c, 8'h0B);

    // Default polynomial: zero stream passes, single 1 fails, rerun from DONE reproduces.
    session_d(1'b0);
    session_d(1'b1);
    session_d(1'b1);

    // Reset after 100 compacted bits.
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    md3 = 1'b1;
    for (int i = 0; i < 101; i++) begin
      so3 = (i == 1);
      tick();
    end
    md3 = 1'b0;
    so3 = 1'b0;
    chk1("d mid busy", busy_d, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("d rst busy", busy_d, 1'b0);
    chk1("d rst done", done_d, 1'b0);
    chk1("d rst pass", pass_d, 1'b0);
    chk8("d rst sig", sig_d, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    session_d(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
